instr_fetch_reg: RTL
====================

// Module: instr_fetch_reg
// PURPOSE
// - Multi-cycle CPU fetch stage: holds PC, issues one instruction-memory read per FetchStart, latches result into IR.
// - Splits IR into decode fields; InstructLow16bits feeds SignExtend directly downstream, Opcode/Funct feed control unit.
// - Control unit pulses FetchStart in its IF state and advances only after IRValid.
// PARAMETERS
// - PC_RESET       32'h0000_0000  PC value after Reset
// - TIMEOUT_CYCLES 16             max REQ cycles before abort (FETCH_TIMEOUT_EN only); legal 1..255
// PORTS
// - CLK               in   1   clock, all state updates on rising edge
// - Reset             in   1   synchronous, active-high
// - FetchStart        in   1   one-cycle request to fetch instruction at PC
// - PCWrite           in   1   load PC from PCNext
// - PCNext            in   32  next PC value; bits [1:0] ignored
// - IMemReq           out  1   read request to instruction memory
// - IMemAddr          out  32  read address, stable while IMemReq=1
// - IMemReady         in   1   memory accepts and returns IMemData this cycle
// - IMemData          in   32  instruction word, sampled when IMemReq&IMemReady
// - IRValid           out  1   IR holds instruction fetched since last FetchStart
// - FetchBusy         out  1   FSM in REQ
// - PC                out  32  current PC (always word aligned)
// - PCPlus4           out  32  PC+4, combinational, mod 2^32
// - Instruction       out  32  IR contents
// - Opcode/Rs/Rt/Rd/Shamt/Funct out 6/5/5/5/5/6  IR[31:26]/[25:21]/[20:16]/[15:11]/[10:6]/[5:0]
// - InstructLow16bits out  16  IR[15:0], to SignExtend
// - FetchError        out  1   sticky timeout flag (0 when FETCH_TIMEOUT_EN undefined)
// BEHAVIOUR
// - Reset: PC=PC_RESET&~3, IR=0, FSM=IDLE, IMemReq=0, IMemAddr=0, IRValid=0, FetchError=0, timeout counter=0.
// - PCWrite: PC<={PCNext[31:2],2'b00} next edge, in any state; PCPlus4 wraps 32'hFFFF_FFFC -> 0.
// - FSM IDLE: FetchStart -> REQ; FetchAddr (drives IMemAddr) <= PCWrite ? {PCNext[31:2],2'b00} : PC; IRValid<=0.
// - FSM REQ: IMemReq=1 (registered, rises cycle after FetchStart); IMemAddr frozen even if PCWrite occurs.
// - REQ & IMemReady: IR<=IMemData, IRValid<=1, IMemReq<=0, -> IDLE. Min latency FetchStart@T -> IRValid/IR visible @T+2.
// - FetchStart while in REQ: ignored, no queueing.
// - IRValid stays 1 and IR stable until next accepted FetchStart; IR never changes outside REQ&IMemReady.
// - Decode outputs purely combinational from IR; no extra latency.
// - Reset mid-REQ: request dropped, IMemReq=0 next cycle, IMemData ignored.
// - Reset wins over FetchStart/PCWrite in same cycle.
// CONFIGURATION
// - FETCH_TIMEOUT_EN defined: counter runs in REQ, clears on REQ entry; if TIMEOUT_CYCLES REQ cycles pass without
//   IMemReady, IMemReq<=0, FSM->IDLE, IRValid stays 0, IR unchanged, FetchError<=1 sticky until Reset.
//   IMemReady in the final counted cycle is accepted (ready wins over timeout).
// - FETCH_TIMEOUT_EN undefined: REQ waits indefinitely; no counter logic; FetchError tied 0.
// TESTING
// - Reset, PC_RESET=32'h0040_0000 -> PC=32'h0040_0000, PCPlus4=32'h0040_0004, IR=0, IRValid=0, IMemReq=0.
// - FetchStart@T, IMemReady=1 always, IMemData=32'h2128_FFFC -> IMemReq@T+1, IRValid@T+2, Opcode=6'h08,
//   Rs=9, Rt=8, InstructLow16bits=16'hFFFC.
// - IMemReady held 0 for 5 cycles, PCWrite PCNext=32'h100 mid-REQ -> IMemAddr unchanged, IR captured on 6th; PC=32'h100.
// - FetchStart+PCWrite same IDLE cycle, PCNext=32'h0000_0207 -> IMemAddr=32'h0000_0204, PC=32'h0000_0204.
// - PCWrite PCNext=32'hFFFF_FFFC -> PCPlus4=0; Reset during REQ -> IMemReq=0 next cycle, IR stays 0.
// - FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, IMemReady=0 -> IMemReq low after 4 REQ cycles, FetchError=1, IRValid=0;
//   repeat with IMemReady on 4th cycle -> IR captured, FetchError=0.

Source files
------------

// File: rtl/instr_fetch_reg_if.sv
// Instruction-memory read port shared by the fetch stage and the memory.
// The fetch side is the master; the memory answers with IMemReady/IMemData.
interface instr_fetch_reg_if;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemReady;
    logic [31:0] IMemData;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemReady,
        input  IMemData
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemReady,
        output IMemData
    );
endinterface

// File: rtl/instr_fetch_reg.sv
// Multi-cycle fetch stage: PC register, one IMEM read per FetchStart, IR + decode.
// Optional macro FETCH_TIMEOUT_EN aborts a read after TIMEOUT_CYCLES and sets FetchError.
module instr_fetch_reg #(
    parameter logic [31:0] PC_RESET       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        FetchStart,
    input  logic        PCWrite,
    input  logic [31:0] PCNext,
    instr_fetch_reg_if.master imem,
    output logic        IRValid,
    output logic        FetchBusy,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [31:0] Instruction,
    output logic [5:0]  Opcode,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [4:0]  Shamt,
    output logic [5:0]  Funct,
    output logic [15:0] InstructLow16bits,
    output logic        FetchError
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    logic [0:0]  state;
    logic [31:0] pc_q;
    logic [31:0] fetch_addr;
    logic [31:0] ir;
    logic        ir_valid;
    logic        timeout;
    logic [31:0] pc_next_aligned;
    logic        unused_pcnext_low;

    // Low address bits are always forced to a word boundary.
    assign pc_next_aligned   = {PCNext[31:2], 2'b00};
    assign unused_pcnext_low = ^PCNext[1:0];

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] LAST_CYCLE = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_cnt;
    logic       fetch_error;

    // Abort when the final counted REQ cycle passes with no ready; ready wins.
    assign timeout = (state == REQ) && !imem.IMemReady && (wait_cnt == LAST_CYCLE);

    // Count REQ cycles from entry; record a sticky error on abort.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            wait_cnt    <= 8'd0;
            fetch_error <= 1'b0;
        end else if (state == IDLE) begin
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (timeout) begin
                fetch_error <= 1'b1;
            end
        end
    end

    assign FetchError = fetch_error;
`else
    assign timeout    = 1'b0;
    assign FetchError = 1'b0;
`endif

    // PC register; PCWrite may load it in any FSM state.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc_q <= {PC_RESET[31:2], 2'b00};
        end else if (PCWrite) begin
            pc_q <= pc_next_aligned;
        end
    end

    // Fetch FSM: latch the address on start, capture IR when memory is ready.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= IDLE;
            fetch_addr <= 32'd0;
            ir         <= 32'd0;
            ir_valid   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (FetchStart) begin
                        state      <= REQ;
                        fetch_addr <= PCWrite ? pc_next_aligned : pc_q;
                        ir_valid   <= 1'b0;
                    end
                end
                REQ: begin
                    if (imem.IMemReady) begin
                        ir       <= imem.IMemData;
                        ir_valid <= 1'b1;
                        state    <= IDLE;
                    end else if (timeout) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign imem.IMemReq  = (state == REQ);
    assign imem.IMemAddr = fetch_addr;
    assign FetchBusy     = (state == REQ);
    assign IRValid       = ir_valid;

    assign PC                = pc_q;
    assign PCPlus4           = pc_q + 32'd4;
    assign Instruction       = ir;
    assign Opcode            = ir[31:26];
    assign Rs                = ir[25:21];
    assign Rt                = ir[20:16];
    assign Rd                = ir[15:11];
    assign Shamt             = ir[10:6];
    assign Funct             = ir[5:0];
    assign InstructLow16bits = ir[15:0];

endmodule
